// File: rtl/picosoc_iomem_master_if.sv
`default_nettype none
// ============================================================================
// Module   : picosoc_iomem_master_if
// Brief    : Host command/response channel plus PicoSoC iomem request bus.
// Revision : 1.0 - initial release
// ============================================================================
interface picosoc_iomem_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    logic        iomem_valid;
    logic        iomem_instr;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output iomem_valid, iomem_instr, iomem_addr, iomem_wdata, iomem_wstrb,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  iomem_valid, iomem_instr, iomem_addr, iomem_wdata, iomem_wstrb,
        output iomem_ready, iomem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/picosoc_iomem_master.sv
`default_nettype none
// ============================================================================
// Module   : picosoc_iomem_master
// Brief    : Single-outstanding host-to-iomem bridge with bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module picosoc_iomem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    picosoc_iomem_master_if.master bus,
    output      logic              busy,
    output      logic [15:0]       err_count
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] C_TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tcnt;
    logic          r_is_read;
    logic          r_iomem_valid;
    logic [31:0]   r_iomem_addr;
    logic [31:0]   r_iomem_wdata;
    logic [3:0]    r_iomem_wstrb;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_error;
    logic [15:0]   r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tcnt        <= '0;
            r_is_read     <= 1'b0;
            r_iomem_valid <= 1'b0;
            r_iomem_addr  <= '0;
            r_iomem_wdata <= '0;
            r_iomem_wstrb <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_iomem_addr  <= bus.cmd_addr & 32'hFFFF_FFFC;
                        r_iomem_wdata <= bus.cmd_wdata;
                        r_iomem_wstrb <= bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
                        r_is_read     <= ~bus.cmd_write;
                        r_tcnt        <= '0;
                        // A write with no enabled bytes has nothing to put on the bus.
                        if (bus.cmd_write && (bus.cmd_wstrb == 4'b0000)) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_error <= 1'b0;
                            r_state     <= S_RESP;
                        end else begin
                            r_iomem_valid <= 1'b1;
                            r_state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (bus.iomem_ready) begin
                        r_iomem_valid <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_is_read ? bus.iomem_rdata : 32'd0;
                        r_rsp_error   <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_tcnt == C_TLAST) begin
                        r_iomem_valid <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_is_read ? ERR_DATA : 32'd0;
                        r_rsp_error   <= 1'b1;
                        if (r_err_count != 16'hFFFF) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        r_state       <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.iomem_valid = r_iomem_valid;
    assign bus.iomem_instr = 1'b0;
    assign bus.iomem_addr  = r_iomem_addr;
    assign bus.iomem_wdata = r_iomem_wdata;
    assign bus.iomem_wstrb = r_iomem_wstrb;
    assign busy            = (r_state != S_IDLE);
    assign err_count       = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_picosoc_iomem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_picosoc_iomem_master
// Brief    : Directed scoreboard bench for picosoc_iomem_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picosoc_iomem_master;
    localparam int unsigned TMO     = 16;
    localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] err_count;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_errs = '0;
    exp_t        sb_q[$];

    picosoc_iomem_master_if bus ();

    picosoc_iomem_master #(
        .TIMEOUT_CYCLES (TMO),
        .ERR_DATA       (ERR_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // wait_c: REQ cycle index (0-based) on which the responder raises ready;
    // values >= TMO mean the responder never answers.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int wait_c,
                          input logic [31:0] rd_val, input int hold);
        exp_t e;
        exp_t got;
        bit   bus_cyc;
        bit   to;
        int   nvalid;
        bus_cyc = !(wr && strb == 4'b0000);
        to      = bus_cyc && (wait_c >= int'(TMO));
        nvalid  = !bus_cyc ? 0 : (to ? int'(TMO) : wait_c + 1);
        e.rdata = wr ? 32'd0 : (to ? ERR_VAL : rd_val);
        e.err   = to;
        if (to && exp_errs != 16'hFFFF) exp_errs = exp_errs + 16'd1;

        chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_wstrb = strb;
        tick();
        sb_q.push_back(e);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_wstrb = 4'($urandom);

        for (int c = 0; c < nvalid; c++) begin
            chk("iomem_valid_req", {31'd0, bus.iomem_valid}, 32'd1);
            chk("iomem_addr", bus.iomem_addr, addr & 32'hFFFF_FFFC);
            chk("iomem_wstrb", {28'd0, bus.iomem_wstrb}, {28'd0, (wr ? strb : 4'b0000)});
            if (wr) chk("iomem_wdata", bus.iomem_wdata, wdata);
            chk("iomem_instr", {31'd0, bus.iomem_instr}, 32'd0);
            chk("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
            chk("rsp_valid_req", {31'd0, bus.rsp_valid}, 32'd0);
            if (c == wait_c) begin
                bus.iomem_ready = 1'b1;
                bus.iomem_rdata = rd_val;
            end else begin
                bus.iomem_ready = 1'b0;
                bus.iomem_rdata = $urandom;
            end
            tick();
        end
        bus.iomem_ready = 1'b0;
        bus.iomem_rdata = $urandom;

        chk("iomem_valid_done", {31'd0, bus.iomem_valid}, 32'd0);
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("busy_resp", {31'd0, busy}, 32'd1);
        got = sb_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, got.rdata);
        chk("rsp_error", {31'd0, bus.rsp_error}, {31'd0, got.err});
        chk("err_count", {16'd0, err_count}, {16'd0, exp_errs});

        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            tick();
            chk("rsp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
            chk("rsp_rdata_hold", bus.rsp_rdata, got.rdata);
            chk("rsp_error_hold", {31'd0, bus.rsp_error}, {31'd0, got.err});
            chk("cmd_ready_hold", {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_clr", {31'd0, bus.rsp_valid}, 32'd0);
        chk("cmd_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.cmd_wstrb   = '0;
        bus.rsp_ready   = 1'b0;
        bus.iomem_ready = 1'b0;
        bus.iomem_rdata = '0;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_iomem_valid", {31'd0, bus.iomem_valid}, 32'd0);
        chk("rst_iomem_addr", bus.iomem_addr, 32'd0);
        chk("rst_iomem_wdata", bus.iomem_wdata, 32'd0);
        chk("rst_iomem_wstrb", {28'd0, bus.iomem_wstrb}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_iomem_instr", {31'd0, bus.iomem_instr}, 32'd0);
        rst = 1'b0;
        tick();

        // Read, immediate ready
        do_txn(1'b0, 32'h0200_0006, 32'h0, 4'b0000, 0, 32'h1234_5678, 0);
        // Write, five wait states
        do_txn(1'b1, 32'h0400_0010, 32'hA5A5_0001, 4'b0011, 5, 32'hDEAD_BEEF, 0);
        // Read timeout
        do_txn(1'b0, 32'h0300_0008, 32'h0, 4'b0000, 1000, 32'h0, 0);
        // Ready exactly on the last allowed cycle
        do_txn(1'b0, 32'h0300_000C, 32'h0, 4'b0000, TMO - 1, 32'hCAFE_F00D, 0);
        // Write with no byte enables: no bus cycle
        do_txn(1'b1, 32'h0500_0000, 32'h1111_2222, 4'b0000, 0, 32'h0, 0);
        // Response back-pressure for 10 cycles
        do_txn(1'b0, 32'h0600_0003, 32'h0, 4'b0000, 2, 32'h8765_4321, 10);
        // Write timeout returns zero data with error
        do_txn(1'b1, 32'h0700_0004, 32'h5555_AAAA, 4'b1100, 1000, 32'h0, 3);

        // Reset pulse mid-REQ abandons the transaction
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0800_0000;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        chk("abort_iomem_valid_pre", {31'd0, bus.iomem_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_errs = '0;
        chk("abort_iomem_valid", {31'd0, bus.iomem_valid}, 32'd0);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_err_count", {16'd0, err_count}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        repeat (4) begin
            tick();
            chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end

        // Normal operation resumes after the abort
        do_txn(1'b0, 32'h0900_0014, 32'h0, 4'b0000, 1, 32'h0F0F_F0F0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/picosoc_iomem_master.md
PICOSOC_IOMEM_MASTER -- requirements
Module: picosoc_iomem_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles iomem_valid is held without iomem_ready before an error completion.
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF, value returned on rsp_rdata for a timed-out read.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  host command offered.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  32  byte address.
REQ-010 cmd_wdata  in  32  write data.
REQ-011 cmd_wstrb  in  4  write byte enables.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  host consumes response.
REQ-014 rsp_rdata  out  32  read data (0 for writes).
REQ-015 rsp_error  out  1  transaction timed out.
REQ-016 iomem_valid  out  1  iomem request.
REQ-017 iomem_instr  out  1  tied 0.
REQ-018 iomem_addr  out  32  request address.
REQ-019 iomem_wdata  out  32  request write data.
REQ-020 iomem_wstrb  out  4  request strobes; 0000 = read.
REQ-021 iomem_ready  in  1  responder completion.
REQ-022 iomem_rdata  in  32  responder read data, valid when iomem_ready=1.
REQ-023 busy  out  1  high in any state other than IDLE.
REQ-024 err_count  out  16  saturating count of timed-out transactions.

Function
REQ-025 FSM states IDLE, REQ, RESP; the block SHALL process one transaction at a time.
REQ-026 cmd_ready SHALL be 1 only in IDLE; handshake = cmd_valid && cmd_ready.
REQ-027 On handshake: latch cmd fields; iomem_addr = {cmd_addr[31:2],2'b00}; iomem_wstrb = cmd_write ? cmd_wstrb : 4'b0000; go REQ.
REQ-028 Write with cmd_wstrb = 0000: no bus cycle; go directly RESP with rsp_rdata=0, rsp_error=0.
REQ-029 In REQ, iomem_valid=1 and iomem_addr/wdata/wstrb SHALL stay constant until completion.
REQ-030 Completion: iomem_ready sampled 1 in REQ -> iomem_valid=0 next cycle, rsp_rdata = read ? iomem_rdata : 0, rsp_error=0, go RESP.
REQ-031 Latency: handshake at edge N -> iomem_valid high cycle N+1; ready at N+1 -> rsp_valid high cycle N+2.
REQ-032 Timeout counter clears on entry to REQ and increments each REQ cycle without ready; reaching TIMEOUT_CYCLES -> iomem_valid=0, rsp_rdata = read ? ERR_DATA : 0, rsp_error=1, err_count+1 (saturating at 16'hFFFF), go RESP.
REQ-033 Ready and timeout in the same cycle: ready wins, no error.
REQ-034 In RESP, rsp_valid=1 with stable rsp_rdata/rsp_error until rsp_ready sampled 1; then IDLE, cmd_ready=1 the following cycle.
REQ-035 iomem_valid SHALL never be high outside REQ; iomem_instr SHALL always be 0.
REQ-036 iomem_rdata SHALL be ignored when iomem_ready=0.

Reset
REQ-037 rst=1 SHALL force IDLE, iomem_valid=0, iomem_addr/wdata=0, iomem_wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, err_count=0, timeout counter=0 on the next edge.
REQ-038 rst asserted mid-REQ or mid-RESP SHALL abandon the transaction with no response; the host SHALL see cmd_ready=1 the first cycle after rst deasserts.

Verification
REQ-039 Read 0x0200_0006, responder ready on first REQ cycle with rdata 0x1234_5678 -> iomem_addr 0x0200_0004, wstrb 0000, rsp_valid at N+2, rsp_rdata 0x1234_5678, rsp_error 0.
REQ-040 Write 0x0400_0010 data 0xA5A5_0001 strb 0011, ready after 5 wait cycles -> signals stable for 6 valid cycles, rsp_rdata 0, rsp_error 0.
REQ-041 Read with iomem_ready held 0, TIMEOUT_CYCLES=16 -> iomem_valid drops after 16 cycles, rsp_rdata 0xFFFF_FFFF, rsp_error 1, err_count 1.
REQ-042 Ready in exactly the timeout cycle -> rsp_error 0, err_count unchanged; write with strb 0000 -> no iomem_valid, rsp_valid next cycle.
REQ-043 rsp_ready held 0 for 10 cycles -> rsp_valid/rdata stable, cmd_ready 0; rst pulse during REQ -> iomem_valid 0 next cycle, no rsp_valid, err_count 0.
